// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C register-transaction master.
// Slot classification helpers keep the top-level FSM and datapath terse.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR_W, ST_ACK_A, ST_REG, ST_ACK_R, ST_WDATA,
    ST_ACK_W, ST_RSTART, ST_ADDR_R, ST_ACK_AR, ST_RDATA, ST_MNACK, ST_STOP
  } state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Bytes shifted out by the master.
  function automatic logic is_tx(input state_e s);
    return (s == ST_ADDR_W) || (s == ST_REG) || (s == ST_WDATA) || (s == ST_ADDR_R);
  endfunction

  // Any 8-slot byte, including the received one.
  function automatic logic is_byte(input state_e s);
    return is_tx(s) || (s == ST_RDATA);
  endfunction

  function automatic logic is_ack(input state_e s);
    return (s == ST_ACK_A) || (s == ST_ACK_R) || (s == ST_ACK_W) || (s == ST_ACK_AR);
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Divides clk_i into 4-phase bus slots; each phase lasts CLK_DIV cycles.
// Held cleared while run is low so every transaction starts on a slot boundary.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       run,
  output logic [1:0] phase,
  output logic       phase_end,
  output logic       slot_end,
  output logic       sample_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign phase_end  = (cnt == CW'(CLK_DIV - 1));
  assign slot_end   = phase_end && (phase == PH3);
  assign sample_stb = phase_end && (phase == PH2);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt   <= '0;
      phase <= PH0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= PH0;
    end else if (phase_end) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte register write/read master driving open-drain SCL/SDA.
// One command per handshake, one response pulse in the first IDLE cycle.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rw_i,
  input  logic [6:0] cmd_dev_addr_i,
  input  logic [7:0] cmd_reg_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_nack_o,
  output logic       busy_o,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       sda_i
);

  state_e     state, state_n;
  logic [1:0] phase;
  logic       phase_end, slot_end, sample_stb;
  logic       accept, rw, nack, sda_smp;
  logic [6:0] dev;
  logic [7:0] reg_a, wdata, sh, sh_load, rx;
  logic [2:0] bit_cnt;

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = !cmd_ready_o;
  assign accept      = cmd_valid_i && cmd_ready_o;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .run        (state != ST_IDLE),
    .phase      (phase),
    .phase_end  (phase_end),
    .slot_end   (slot_end),
    .sample_stb (sample_stb)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= ST_IDLE;
    else        state <= state_n;
  end

  // sda_smp is refreshed at every phase end, so at slot_end it still holds the ph2 sample.
  always_comb begin
    state_n  = state;
    sh_load  = sh;
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    if (state == ST_IDLE) begin
      if (cmd_valid_i) state_n = ST_START;
    end else if (slot_end) begin
      unique case (state)
        ST_START:  state_n = ST_ADDR_W;
        ST_ADDR_W: if (bit_cnt == 3'd0) state_n = ST_ACK_A;
        ST_ACK_A:  state_n = sda_smp ? ST_STOP : ST_REG;
        ST_REG:    if (bit_cnt == 3'd0) state_n = ST_ACK_R;
        ST_ACK_R:  state_n = sda_smp ? ST_STOP : ((rw == RW_READ) ? ST_RSTART : ST_WDATA);
        ST_WDATA:  if (bit_cnt == 3'd0) state_n = ST_ACK_W;
        ST_ACK_W:  state_n = ST_STOP;
        ST_RSTART: state_n = ST_ADDR_R;
        ST_ADDR_R: if (bit_cnt == 3'd0) state_n = ST_ACK_AR;
        ST_ACK_AR: state_n = sda_smp ? ST_STOP : ST_RDATA;
        ST_RDATA:  if (bit_cnt == 3'd0) state_n = ST_MNACK;
        ST_MNACK:  state_n = ST_STOP;
        ST_STOP:   state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end

    unique case (state_n)
      ST_ADDR_W: sh_load = {dev, 1'b0};
      ST_REG:    sh_load = reg_a;
      ST_WDATA:  sh_load = wdata;
      ST_ADDR_R: sh_load = {dev, 1'b1};
      default:   sh_load = sh;
    endcase

    unique case (state)
      ST_IDLE:   scl_oe_o = 1'b0;
      ST_START:  scl_oe_o = (phase == PH3);
      ST_RSTART: scl_oe_o = (phase == PH0) || (phase == PH3);
      ST_STOP:   scl_oe_o = (phase == PH0);
      default:   scl_oe_o = (phase <= PH1);
    endcase

    if (state == ST_START || state == ST_RSTART) sda_oe_o = (phase >= PH2);
    else if (state == ST_STOP)                   sda_oe_o = (phase <= PH1);
    else if (is_tx(state))                       sda_oe_o = !sh[7];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rw          <= RW_WRITE;
      dev         <= '0;
      reg_a       <= '0;
      wdata       <= '0;
      sh          <= '0;
      rx          <= '0;
      bit_cnt     <= 3'd7;
      nack        <= 1'b0;
      sda_smp     <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_nack_o  <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (accept) begin
        rw          <= cmd_rw_i;
        dev         <= cmd_dev_addr_i;
        reg_a       <= cmd_reg_addr_i;
        wdata       <= cmd_wdata_i;
        bit_cnt     <= 3'd7;
        nack        <= 1'b0;
        rsp_rdata_o <= '0;
        rsp_nack_o  <= 1'b0;
      end
      if (phase_end) sda_smp <= sda_i;
      if (sample_stb && state == ST_RDATA) rx <= {rx[6:0], sda_i};
      if (slot_end) begin
        // bit_cnt wraps 0 -> 7 at the end of each byte, ready for the next one.
        if (is_byte(state)) bit_cnt <= bit_cnt - 3'd1;
        if (is_ack(state) && sda_smp) nack <= 1'b1;
        if (state_n != state && is_tx(state_n)) sh <= sh_load;
        else                                    sh <= {sh[6:0], 1'b0};
        if (state == ST_STOP) begin
          rsp_valid_o <= 1'b1;
          rsp_nack_o  <= nack;
          rsp_rdata_o <= (rw == RW_READ && !nack) ? rx : 8'h00;
        end
      end
    end
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Clocked I2C master that sequences complete single-byte register transactions toward i2c_slave-style devices.
- Accepts one command per valid/ready handshake and executes it on the bus:
  - Write: START, dev+W, reg, data, STOP.
  - Read: START, dev+W, reg, repeated START, dev+R, data, master NACK, STOP.
- Returns one response (read data and NACK flag) per command.
- Sits between the host command source and the open-drain SCL/SDA pads. Drives the bus only by pulling low.

Parameters:
CLK_DIV, 125, clk_i cycles per quarter bit-slot (125 gives 100 kHz at 50 MHz); minimum 2.

Ports:
clk_i  in  1  system clock
arst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  controller idle, can accept a command
cmd_rw_i  in  1  0 = register write, 1 = register read
cmd_dev_addr_i  in  7  target device address
cmd_reg_addr_i  in  8  target register address
cmd_wdata_i  in  8  write data, ignored for reads
rsp_valid_o  out  1  one-cycle pulse: command finished
rsp_rdata_o  out  8  read byte; 0 for writes or on NACK
rsp_nack_o  out  1  1 = some slave ACK slot read high
busy_o  out  1  transaction in progress
scl_oe_o  out  1  1 = pull SCL low, 0 = release
sda_oe_o  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset values (asynchronous, outputs valid immediately):
  - scl_oe_o = 0, sda_oe_o = 0, busy_o = 0, cmd_ready_o = 1.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_nack_o = 0.
  - FSM in IDLE, timer cleared.
- Handshake:
  - cmd_ready_o = (state == IDLE).
  - A command is accepted on a clock edge where cmd_valid_i && cmd_ready_o. All cmd_* fields are registered at that edge.
  - cmd_valid_i is ignored while busy. No queueing.
- Timing:
  - Every bus element is one slot of 4 phases (ph0..ph3), each CLK_DIV cycles long.
  - The phase tick comes from the timer.
- Data/ACK slot:
  - SCL is pulled low during ph0–ph1 and released during ph2–ph3.
  - SDA is updated at the start of ph0.
  - sda_i is sampled on the last cycle of ph2.
  - Data is sent MSB first.
- START slot:
  - ph0–ph1: SCL and SDA both released.
  - ph2: SDA low.
  - ph3: SDA low, SCL low.
- RSTART slot: identical to START, except ph0 SCL is low.
- STOP slot:
  - ph0: SCL low, SDA low.
  - ph1: SCL released, SDA low.
  - ph2–ph3: both released.
- FSM states:
  - IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_W, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP.
- Transitions:
  - IDLE → START on accept.
  - START → ADDR_W → ACK_A → REG → ACK_R.
  - ACK_R → WDATA (rw = 0) or RSTART (rw = 1).
  - Write path: WDATA → ACK_W → STOP.
  - Read path: RSTART → ADDR_R → ACK_AR → RDATA → MNACK → STOP.
  - STOP → IDLE.
- Shift content:
  - ADDR_W sends {dev, 0}; ADDR_R sends {dev, 1}.
  - The bit counter runs 7..0, and the state advances after bit 0.
- ACK slots (ACK_A, ACK_R, ACK_W, ACK_AR):
  - SDA is released.
  - Sampled 0 = ACK.
  - Sampled 1 = set nack flag and go directly to STOP.
- RDATA: SDA released; the 8 samples are shifted in MSB first.
- MNACK: SDA released (master NACK, single-byte read).
- Completion:
  - Upon the STOP slot completing, the FSM enters IDLE.
  - rsp_valid_o pulses high for one cycle in the first IDLE cycle. rsp_rdata_o and rsp_nack_o are valid with it and held until the next accept.
  - cmd_ready_o is already 1 in that cycle, so back-to-back commands are legal.
- Latency from accept to rsp_valid_o:
  - Write: 29 slots × 4 × CLK_DIV + 1 cycles.
  - Read: 39 slots × 4 × CLK_DIV + 1 cycles.
  - NACK at the first ACK: 11 slots × 4 × CLK_DIV + 1 cycles.
- busy_o = !cmd_ready_o.
- Reset mid-transaction:
  - Both lines are released immediately and no response is issued.
  - The bus may be left mid-frame; recovery is the host's responsibility.
- Not supported: clock stretching and multi-master arbitration.

Decomposition:
- Package i2c_pkg:
  - FSM state enum.
  - Phase index constants PH0..PH3.
  - RW encodings RW_WRITE = 0, RW_READ = 1.
- Sub-module i2c_bit_timer:
  - Parameter CLK_DIV; cycle counter of width $clog2(CLK_DIV).
  - Outputs phase[1:0], phase_end, slot_end, sample_stb.
  - Inputs: clk_i, arst_i, run (clears the timer when low).

Test Plan:
All scenarios use CLK_DIV = 4 (slot = 16 cycles) and a behavioural slave at address 0x50 holding reg 0x12 = 0x3C.
1. Write dev 0x50, reg 0x12, wdata 0xA5 → bus bytes 0xA0, 0x12, 0xA5, all ACKed; rsp_valid_o exactly 465 cycles after accept; rsp_nack_o = 0, rsp_rdata_o = 0.
2. Read dev 0x50, reg 0x12 → bytes 0xA0, 0x12, RSTART, 0xA1; receives 0x3C; master NACK, then STOP; rsp_rdata_o = 0x3C; latency 625 cycles.
3. Write to dev 0x51 (no responder, ACK slot high) → STOP follows the first ACK slot; rsp_nack_o = 1, rsp_rdata_o = 0; latency 177 cycles.
4. cmd_valid_i held high with different fields during a busy transfer → cmd_ready_o = 0, the fields are not captured, and the bus bytes match the first command; the second command is accepted in the rsp_valid_o cycle.
5. arst_i pulse during the REG byte → scl_oe_o = sda_oe_o = 0 within the same cycle, no rsp_valid_o, cmd_ready_o = 1; a subsequent write completes normally.
6. Protocol checker throughout all scenarios → SDA changes only while SCL is low, except in START/RSTART/STOP slots; START/STOP edges appear only where scheduled.
